pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central hazard and sequencing controller for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB). It owns the per-stage valid bits and generates stall, bubble, flush and redirect controls. It also produces the EX-stage operand forwarding selects. At writeback it emits the per-instruction commit strobes (`o_insn_vld`, `o_ctrl`, `o_mispred`) consumed by the top-level debug ports and the ISA-test scoreboard.

## Interface
Parameters:
- REG_AW, 5, register address width
- FWD_W, 2, forwarding select width

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset, synchronous, active-low
- i_if_vld  in  1  IF delivers an instruction to ID this cycle
- i_id_rs1 / i_id_rs2  in  REG_AW  ID source registers
- i_id_use_rs1 / i_id_use_rs2  in  1  ID instruction reads rs1/rs2
- i_id_ctrl  in  1  ID instruction is a branch/jal/jalr
- i_ex_rs1 / i_ex_rs2  in  REG_AW  EX source registers
- i_ex_rd / i_mem_rd / i_wb_rd  in  REG_AW  destination register per stage
- i_ex_wen / i_mem_wen / i_wb_wen  in  1  stage writes the register file
- i_ex_load  in  1  EX instruction is a load
- i_ex_mispred  in  1  branch resolved in EX disagrees with prediction
- i_lsu_busy  in  1  data memory access in MEM not yet complete
- o_stall_if / o_stall_id  out  1  hold PC / IF-ID register
- o_bubble_ex  out  1  load ID-EX register with a NOP
- o_flush_id  out  1  squash the IF-ID register contents
- o_redirect  out  1  PC takes the EX-computed target
- o_fwd_a / o_fwd_b  out  FWD_W  EX operand select: 00 regfile, 01 MEM, 10 WB
- o_insn_vld / o_ctrl / o_mispred  out  1  commit strobes for the WB instruction

## Operation
- Internal registers: `id_vld`, `ex_vld`, `mem_vld`, `wb_vld`, plus `ctrl` and `mispred` flags carried alongside each stage from ID (ctrl) or EX (mispred) to WB.
- A stage's rd/wen inputs count as a producer only when that stage's valid bit is set.
- Register x0 never matches any producer.
- Advance rule, applied when `i_lsu_busy`=0:
  - valids shift one stage toward WB;
  - `id_vld` loads `i_if_vld`.
- Freeze:
  - `i_lsu_busy`=1 holds every valid/flag register.
  - It asserts `o_stall_if` and `o_stall_id`.
  - It deasserts `o_bubble_ex`, `o_flush_id` and `o_redirect`.
  - A freeze overrides all other events.
- Load-use (RAW) stall:
  - Asserts `o_stall_if`, `o_stall_id` and `o_bubble_ex` for one cycle.
  - `ex_vld` is set to 0 on the next edge.
  - `id_vld` holds.
- Misprediction: `ex_vld` & EX ctrl flag & `i_ex_mispred`.
  - Asserts `o_redirect` and `o_flush_id`, and sets `ex_vld`=0 for the incoming slot.
  - `id_vld` is cleared on the next edge.
  - The mispredicted instruction itself proceeds and commits with `o_mispred`=1.
- Simultaneous misprediction and RAW stall: the misprediction wins. The stalled ID instruction is squashed, and no stall is asserted.
- Commit: `o_insn_vld` = `wb_vld`; `o_ctrl` = `wb_vld` & wb ctrl flag; `o_mispred` = `wb_vld` & wb mispred flag. Each strobe is exactly one cycle per retired instruction.
- Forwarding (PIPE_FWD_EN only), per EX operand:
  - MEM match with `mem_vld` & `i_mem_wen` selects 01.
  - Otherwise a WB match with `wb_vld` & `i_wb_wen` selects 10.
  - Otherwise 00.
  - MEM has priority over WB.

## Timing
- Every output is 0 while `i_reset`=0 and on the first cycle after release. All valid/flag registers reset to 0.
- Stall, bubble, flush, redirect and forwarding outputs are combinational from the current inputs and state. Commit strobes are driven from registered state only.
- Load-use penalty is 1 cycle. Misprediction penalty is 2 cycles (two squashed slots).
- An instruction entering ID on cycle N commits on N+3 if no stall or freeze occurs.
- A misprediction held during a freeze stays pending. It is applied on the first cycle with `i_lsu_busy`=0.
- Reset asserted mid-operation clears all in-flight instructions on the next edge. No commit strobe is emitted for them.

## Configuration
- `PIPE_FWD_EN` defined:
  - forwarding selects active;
  - RAW stall only when EX holds a load whose rd matches a used ID source.
- `PIPE_FWD_EN` undefined:
  - `o_fwd_a`/`o_fwd_b` are tied to 00;
  - RAW stall whenever a used ID source matches a valid writing EX or MEM rd;
  - the register file write-through covers WB.

## Structure
- `pipe_ctrl_pkg` holds:
  - `fwd_sel_e` enum (`FWD_RF`=00, `FWD_MEM`=01, `FWD_WB`=10);
  - `stage_info_t` struct (vld, ctrl, mispred);
  - `REG_AW`.
- Sub-module `pipe_raw_detect`: purely combinational comparator with x0 exclusion. It is instantiated once for ID hazard detection and twice for the EX forwarding selects.

## Test plan
- Reset held 3 cycles with `i_if_vld`=1 → every output 0; first `o_insn_vld` occurs 4 cycles after release.
- `lw x5` in EX, ID `add x6,x5,x1` → one cycle with `o_stall_if`/`o_stall_id`/`o_bubble_ex`=1; with PIPE_FWD_EN the add later sees `o_fwd_a`=10.
- `addi x7` in MEM, EX reads x7 with WB also writing x7 → `o_fwd_a`=01 (MEM priority); rs=x0 → 00.
- Branch in EX with `i_ex_mispred`=1 → `o_redirect`=`o_flush_id`=1; the next two commit slots are empty; the branch commits with `o_ctrl`=`o_mispred`=1.
- `i_lsu_busy`=1 for 4 cycles while a misprediction is pending → no redirect during the freeze; redirect on the release cycle; commit count unchanged.
- 100 independent instructions with no hazards → 100 `o_insn_vld` pulses over 103 cycles after the first fetch.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

   localparam int REG_AW = 5;
   localparam int FWD_W  = 2;

   // EX operand source select.
   typedef enum logic [FWD_W-1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_e;

   // Per-stage bookkeeping carried alongside each in-flight instruction.
   typedef struct packed {
      logic vld;
      logic ctrl;
      logic mispred;
   } stage_info_t;

   localparam stage_info_t STAGE_EMPTY = '{vld: 1'b0, ctrl: 1'b0, mispred: 1'b0};

endpackage

// File: rtl/pipe_raw_detect.sv
// Register-dependency comparator: checks N_SRC source registers against two
// producer destinations. A producer with rd = x0 never matches.
module pipe_raw_detect import pipe_ctrl_pkg::*; #(
   parameter int N_SRC = 1,
   parameter int AW    = REG_AW
) (
   input  logic [N_SRC-1:0][AW-1:0] src_rs_i,
   input  logic [N_SRC-1:0]         src_use_i,
   input  logic [AW-1:0]            p0_rd_i,
   input  logic                     p0_en_i,
   input  logic [AW-1:0]            p1_rd_i,
   input  logic                     p1_en_i,
   output logic [N_SRC-1:0]         hit_p0_o,
   output logic [N_SRC-1:0]         hit_p1_o
);

   // Per-source match against each enabled, non-x0 producer.
   always_comb begin
      // NOTE: every output gets a default before the loop, so no bit can hold its old value (no latch).
      hit_p0_o = '0;
      hit_p1_o = '0;
      for (int i = 0; i < N_SRC; i++) begin
         hit_p0_o[i] = src_use_i[i] & p0_en_i & (p0_rd_i != '0) & (src_rs_i[i] == p0_rd_i);
         hit_p1_o[i] = src_use_i[i] & p1_en_i & (p1_rd_i != '0) & (src_rs_i[i] == p1_rd_i);
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stage valid
// bits, stall/bubble/flush/redirect, EX forwarding selects, WB commit strobes.
// Build option: define PIPE_FWD_EN to enable operand forwarding; without it
// the forwarding selects read 00 and any EX/MEM producer stalls ID.
module pipe_hazard_ctrl #(
   parameter int REG_AW = pipe_ctrl_pkg::REG_AW,
   parameter int FWD_W  = pipe_ctrl_pkg::FWD_W
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_if_vld,
   input  logic [REG_AW-1:0] i_id_rs1,
   input  logic [REG_AW-1:0] i_id_rs2,
   input  logic              i_id_use_rs1,
   input  logic              i_id_use_rs2,
   input  logic              i_id_ctrl,
   input  logic [REG_AW-1:0] i_ex_rs1,
   input  logic [REG_AW-1:0] i_ex_rs2,
   input  logic [REG_AW-1:0] i_ex_rd,
   input  logic [REG_AW-1:0] i_mem_rd,
   input  logic [REG_AW-1:0] i_wb_rd,
   input  logic              i_ex_wen,
   input  logic              i_mem_wen,
   input  logic              i_wb_wen,
   input  logic              i_ex_load,
   input  logic              i_ex_mispred,
   input  logic              i_lsu_busy,
   output logic              o_stall_if,
   output logic              o_stall_id,
   output logic              o_bubble_ex,
   output logic              o_flush_id,
   output logic              o_redirect,
   output logic [FWD_W-1:0]  o_fwd_a,
   output logic [FWD_W-1:0]  o_fwd_b,
   output logic              o_insn_vld,
   output logic              o_ctrl,
   output logic              o_mispred
);
   import pipe_ctrl_pkg::*;

`ifdef PIPE_FWD_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif

   stage_info_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   logic        id_vld_q, id_vld_d;
   logic        wb_done_q, wb_done_d;   // WB strobe already issued while frozen
   logic        active_q;               // low on the first cycle after reset release
   logic        run, frz, mispred, raw_hit, raw_stall;
   logic        id_ex_en, id_mem_en;
   logic [1:0]  id_hit_p0, id_hit_p1;
   logic        fa_mem, fa_wb, fb_mem, fb_wb;
   fwd_sel_e    fwd_a_sel, fwd_b_sel;

   assign run     = i_reset & active_q;
   assign frz     = run & i_lsu_busy;
   assign mispred = run & ex_q.vld & ex_q.ctrl & i_ex_mispred;

   // With forwarding only a load in EX can hurt ID; without it any EX/MEM writer does.
   assign id_ex_en  = ex_q.vld & i_ex_wen & (i_ex_load | !FWD_ON);
   assign id_mem_en = mem_q.vld & i_mem_wen & !FWD_ON;

   pipe_raw_detect #(.N_SRC(2), .AW(REG_AW)) u_id_raw (
      .src_rs_i  ({i_id_rs2, i_id_rs1}),
      .src_use_i ({i_id_use_rs2, i_id_use_rs1}),
      .p0_rd_i   (i_ex_rd),
      .p0_en_i   (id_ex_en),
      .p1_rd_i   (i_mem_rd),
      .p1_en_i   (id_mem_en),
      .hit_p0_o  (id_hit_p0),
      .hit_p1_o  (id_hit_p1)
   );

   pipe_raw_detect #(.N_SRC(1), .AW(REG_AW)) u_fwd_a (
      .src_rs_i  (i_ex_rs1),
      .src_use_i (1'b1),
      .p0_rd_i   (i_mem_rd),
      .p0_en_i   (mem_q.vld & i_mem_wen),
      .p1_rd_i   (i_wb_rd),
      .p1_en_i   (wb_q.vld & i_wb_wen),
      .hit_p0_o  (fa_mem),
      .hit_p1_o  (fa_wb)
   );

   pipe_raw_detect #(.N_SRC(1), .AW(REG_AW)) u_fwd_b (
      .src_rs_i  (i_ex_rs2),
      .src_use_i (1'b1),
      .p0_rd_i   (i_mem_rd),
      .p0_en_i   (mem_q.vld & i_mem_wen),
      .p1_rd_i   (i_wb_rd),
      .p1_en_i   (wb_q.vld & i_wb_wen),
      .hit_p0_o  (fb_mem),
      .hit_p1_o  (fb_wb)
   );

   assign raw_hit   = |{id_hit_p0, id_hit_p1};
   // A misprediction squashes the ID instruction, so its hazard is moot.
   assign raw_stall = run & id_vld_q & raw_hit & !mispred;

   // Reset-release tracker keeps combinational controls quiet for one cycle.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (!i_reset) active_q <= 1'b0;
      else          active_q <= 1'b1;
   end

   // Next state: hold on freeze, otherwise advance with squash/stall overrides.
   always_comb begin
      id_vld_d  = id_vld_q;
      ex_d      = ex_q;
      mem_d     = mem_q;
      wb_d      = wb_q;
      wb_done_d = wb_done_q | wb_q.vld;
      if (!frz) begin
         wb_done_d     = 1'b0;
         wb_d          = mem_q;
         mem_d         = ex_q;
         mem_d.mispred = mispred;
         ex_d          = '{vld: id_vld_q, ctrl: id_vld_q & i_id_ctrl, mispred: 1'b0};
         id_vld_d      = i_if_vld;
         if (mispred) begin
            ex_d     = STAGE_EMPTY;
            id_vld_d = 1'b0;
         end else if (raw_stall) begin
            ex_d     = STAGE_EMPTY;
            id_vld_d = id_vld_q;
         end
      end
   end

   // Stage valid/flag registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         id_vld_q  <= 1'b0;
         ex_q      <= STAGE_EMPTY;
         mem_q     <= STAGE_EMPTY;
         wb_q      <= STAGE_EMPTY;
         wb_done_q <= 1'b0;
      end else begin
         id_vld_q  <= id_vld_d;
         ex_q      <= ex_d;
         mem_q     <= mem_d;
         wb_q      <= wb_d;
         wb_done_q <= wb_done_d;
      end
   end

   // Forwarding priority: MEM over WB over register file.
   always_comb begin
      fwd_a_sel = FWD_RF;
      fwd_b_sel = FWD_RF;
      if (fa_mem)     fwd_a_sel = FWD_MEM;
      else if (fa_wb) fwd_a_sel = FWD_WB;
      if (fb_mem)     fwd_b_sel = FWD_MEM;
      else if (fb_wb) fwd_b_sel = FWD_WB;
   end

   // Pipeline control outputs; a freeze masks bubble, flush and redirect.
   always_comb begin
      o_stall_if  = frz | raw_stall;
      o_stall_id  = frz | raw_stall;
      o_bubble_ex = !frz & raw_stall;
      o_flush_id  = !frz & mispred;
      o_redirect  = !frz & mispred;
      o_fwd_a     = FWD_W'(FWD_RF);
      o_fwd_b     = FWD_W'(FWD_RF);
      if (FWD_ON && run) begin
         o_fwd_a = FWD_W'(fwd_a_sel);
         o_fwd_b = FWD_W'(fwd_b_sel);
      end
   end

   // Commit strobes from registered state; a held WB slot strobes only once.
   assign o_insn_vld = wb_q.vld & !wb_done_q;
   assign o_ctrl     = o_insn_vld & wb_q.ctrl;
   assign o_mispred  = o_insn_vld & wb_q.mispred;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl. Output vector layout:
// {stall_if, stall_id, bubble_ex, flush_id, redirect, fwd_a[1:0], fwd_b[1:0],
//  insn_vld, ctrl, mispred}. Expectations follow PIPE_FWD_EN when defined.
module tb_pipe_hazard_ctrl;

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic       i_if_vld;
   logic [4:0] i_id_rs1, i_id_rs2, i_ex_rs1, i_ex_rs2, i_ex_rd, i_mem_rd, i_wb_rd;
   logic       i_id_use_rs1, i_id_use_rs2, i_id_ctrl;
   logic       i_ex_wen, i_mem_wen, i_wb_wen, i_ex_load, i_ex_mispred, i_lsu_busy;
   logic       o_stall_if, o_stall_id, o_bubble_ex, o_flush_id, o_redirect;
   logic [1:0] o_fwd_a, o_fwd_b;
   logic       o_insn_vld, o_ctrl, o_mispred;
   logic [11:0] obs;

   int total = 0;
   int bad   = 0;

`ifdef PIPE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   always #5 i_clk = ~i_clk;

   assign obs = {o_stall_if, o_stall_id, o_bubble_ex, o_flush_id, o_redirect,
                 o_fwd_a, o_fwd_b, o_insn_vld, o_ctrl, o_mispred};

   pipe_hazard_ctrl dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_if_vld(i_if_vld),
      .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
      .i_id_use_rs1(i_id_use_rs1), .i_id_use_rs2(i_id_use_rs2), .i_id_ctrl(i_id_ctrl),
      .i_ex_rs1(i_ex_rs1), .i_ex_rs2(i_ex_rs2),
      .i_ex_rd(i_ex_rd), .i_mem_rd(i_mem_rd), .i_wb_rd(i_wb_rd),
      .i_ex_wen(i_ex_wen), .i_mem_wen(i_mem_wen), .i_wb_wen(i_wb_wen),
      .i_ex_load(i_ex_load), .i_ex_mispred(i_ex_mispred), .i_lsu_busy(i_lsu_busy),
      .o_stall_if(o_stall_if), .o_stall_id(o_stall_id), .o_bubble_ex(o_bubble_ex),
      .o_flush_id(o_flush_id), .o_redirect(o_redirect),
      .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b),
      .o_insn_vld(o_insn_vld), .o_ctrl(o_ctrl), .o_mispred(o_mispred)
   );

   task automatic next_cycle();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle();
      i_if_vld = 0; i_id_rs1 = 0; i_id_rs2 = 0; i_id_use_rs1 = 0; i_id_use_rs2 = 0;
      i_id_ctrl = 0; i_ex_rs1 = 0; i_ex_rs2 = 0; i_ex_rd = 0; i_mem_rd = 0; i_wb_rd = 0;
      i_ex_wen = 0; i_mem_wen = 0; i_wb_wen = 0; i_ex_load = 0; i_ex_mispred = 0;
      i_lsu_busy = 0;
   endtask

   task automatic drain(input int n);
      idle();
      for (int i = 0; i < n; i++) next_cycle();
   endtask

   task automatic test_reset();
      logic [11:0] exp;
      idle();
      i_reset = 0; i_if_vld = 1; i_lsu_busy = 1;
      for (int c = 0; c < 3; c++) begin
         next_cycle(); #2;
         total++;
         if (obs !== 12'b0) begin
            bad++; $display("FAIL reset_hold[%0d]: got %b want %b", c, obs, 12'b0);
         end
      end
      i_reset = 1; i_lsu_busy = 0; #1;
      total++;
      if (obs !== 12'b0) begin
         bad++; $display("FAIL reset_release: got %b want %b", obs, 12'b0);
      end
      for (int k = 1; k <= 5; k++) begin
         next_cycle(); #2;
         exp = (k >= 4) ? 12'b00000_00_00_100 : 12'b0;
         total++;
         if (obs !== exp) begin
            bad++; $display("FAIL reset_first_commit[+%0d]: got %b want %b", k, obs, exp);
         end
      end
      drain(6);
   endtask

   task automatic test_load_use();
      logic [11:0] exp;
      next_cycle(); i_if_vld = 1;                       // lw x5 fetched
      next_cycle(); i_if_vld = 1;                       // add x6,x5,x1 fetched
      for (int k = 2; k <= 7; k++) begin
         next_cycle();
         i_if_vld = 0;
         case (k)
            2: begin
               i_ex_rd = 5; i_ex_wen = 1; i_ex_load = 1;
               i_id_rs1 = 5; i_id_rs2 = 1; i_id_use_rs1 = 1; i_id_use_rs2 = 1;
            end
            3: begin
               i_ex_rd = 0; i_ex_wen = 0; i_ex_load = 0;
               i_mem_rd = 5; i_mem_wen = 1;
            end
            4: begin
               i_mem_rd = 0; i_mem_wen = 0; i_wb_rd = 5; i_wb_wen = 1;
               i_ex_rs1 = 5; i_ex_rs2 = 1;
            end
            5: begin
               i_wb_rd = 0; i_wb_wen = 0; i_ex_rs1 = 0; i_ex_rs2 = 0;
               i_id_use_rs1 = 0; i_id_use_rs2 = 0;
            end
            default: ;
         endcase
         #2;
         if (FWD) begin
            case (k)
               2: exp = 12'b11100_00_00_000;
               4: exp = 12'b00000_10_00_100;
               6: exp = 12'b00000_00_00_100;
               default: exp = 12'b0;
            endcase
         end else begin
            case (k)
               2, 3: exp = 12'b11100_00_00_000;
               4, 7: exp = 12'b00000_00_00_100;
               default: exp = 12'b0;
            endcase
         end
         total++;
         if (obs !== exp) begin
            bad++; $display("FAIL load_use[A+%0d]: got %b want %b", k, obs, exp);
         end
      end
      drain(6);
   endtask

   task automatic test_fwd_priority();
      logic [11:0] exp;
      for (int i = 0; i < 3; i++) begin next_cycle(); i_if_vld = 1; end
      next_cycle(); i_if_vld = 0;
      next_cycle();                                      // I0 WB, I1 MEM, I2 EX
      for (int p = 0; p < 4; p++) begin
         case (p)
            0: begin i_ex_rs1 = 7; i_ex_rs2 = 0; i_mem_rd = 7; i_mem_wen = 1; i_wb_rd = 7; i_wb_wen = 1; end
            1: begin i_ex_rs2 = 9; i_wb_rd = 9; end
            2: begin i_mem_wen = 0; i_ex_rs2 = 7; i_wb_rd = 7; end
            default: begin i_ex_rs1 = 0; i_ex_rs2 = 0; i_mem_rd = 0; i_mem_wen = 1; i_wb_rd = 0; end
         endcase
         #1;
         case (p)
            0: exp = FWD ? 12'b00000_01_00_100 : 12'b00000_00_00_100;
            1: exp = FWD ? 12'b00000_01_10_100 : 12'b00000_00_00_100;
            2: exp = FWD ? 12'b00000_10_10_100 : 12'b00000_00_00_100;
            default: exp = 12'b00000_00_00_100;
         endcase
         total++;
         if (obs !== exp) begin
            bad++; $display("FAIL fwd_pattern[%0d]: got %b want %b", p, obs, exp);
         end
      end
      next_cycle();                                      // I1 WB, I2 MEM, EX empty
      i_ex_rs1 = 3; i_ex_rs2 = 0; i_mem_rd = 3; i_mem_wen = 1; i_wb_rd = 3; i_wb_wen = 1;
      #2;
      exp = FWD ? 12'b00000_01_00_100 : 12'b00000_00_00_100;
      total++;
      if (obs !== exp) begin
         bad++; $display("FAIL fwd_mem_valid: got %b want %b", obs, exp);
      end
      next_cycle();                                      // I2 WB, MEM empty
      i_ex_rs1 = 3; i_ex_rs2 = 4; i_mem_rd = 3; i_mem_wen = 1; i_wb_rd = 4; i_wb_wen = 1;
      #2;
      exp = FWD ? 12'b00000_00_10_100 : 12'b00000_00_00_100;
      total++;
      if (obs !== exp) begin
         bad++; $display("FAIL fwd_mem_invalid: got %b want %b", obs, exp);
      end
      next_cycle();                                      // WB empty
      #2;
      total++;
      if (obs !== 12'b0) begin
         bad++; $display("FAIL fwd_wb_invalid: got %b want %b", obs, 12'b0);
      end
      drain(6);
   endtask

   task automatic test_mispredict();
      logic [11:0] exp;
      next_cycle(); i_if_vld = 1;                        // branch fetched
      next_cycle(); i_if_vld = 1; i_id_ctrl = 1;         // branch in ID
      for (int k = 2; k <= 8; k++) begin
         next_cycle();
         case (k)
            2: begin
               // load-use hazard forced alongside the misprediction
               i_if_vld = 1; i_id_ctrl = 0; i_ex_mispred = 1;
               i_ex_rd = 1; i_ex_wen = 1; i_ex_load = 1; i_id_rs1 = 1; i_id_use_rs1 = 1;
            end
            3: begin
               i_if_vld = 1; i_ex_mispred = 0; i_ex_rd = 0; i_ex_wen = 0; i_ex_load = 0;
               i_id_rs1 = 0; i_id_use_rs1 = 0;
            end
            default: i_if_vld = 0;
         endcase
         #2;
         case (k)
            2: exp = 12'b00011_00_00_000;
            4: exp = 12'b00000_00_00_111;
            7: exp = 12'b00000_00_00_100;
            default: exp = 12'b0;
         endcase
         total++;
         if (obs !== exp) begin
            bad++; $display("FAIL mispredict[C%0d]: got %b want %b", k, obs, exp);
         end
      end
      drain(6);
   endtask

   task automatic test_freeze_mispred();
      logic [11:0] exp;
      int commits = 0;
      for (int k = 0; k <= 12; k++) begin
         next_cycle();
         i_if_vld     = (k <= 3);
         i_id_ctrl    = (k == 3);
         i_lsu_busy   = (k >= 4 && k <= 7);
         i_ex_mispred = (k >= 4 && k <= 8);
         #2;
         case (k)
            4:          exp = 12'b11000_00_00_100;
            5, 6, 7:    exp = 12'b11000_00_00_000;
            8:          exp = 12'b00011_00_00_000;
            9:          exp = 12'b00000_00_00_100;
            10:         exp = 12'b00000_00_00_111;
            default:    exp = 12'b0;
         endcase
         commits += int'(o_insn_vld);
         total++;
         if (obs !== exp) begin
            bad++; $display("FAIL freeze[C%0d]: got %b want %b", k, obs, exp);
         end
      end
      total++;
      if (commits !== 3) begin
         bad++; $display("FAIL freeze_commit_count: got %0d want 3", commits);
      end
      drain(6);
   endtask

   task automatic test_back_to_back();
      logic [11:0] exp;
      int pulses = 0;
      for (int k = 0; k < 108; k++) begin
         next_cycle();
         i_if_vld = (k < 100);
         #2;
         exp = (k >= 4 && k <= 103) ? 12'b00000_00_00_100 : 12'b0;
         pulses += int'(o_insn_vld);
         total++;
         if (obs !== exp) begin
            bad++; $display("FAIL back_to_back[%0d]: got %b want %b", k, obs, exp);
         end
      end
      total++;
      if (pulses !== 100) begin
         bad++; $display("FAIL back_to_back_count: got %0d want 100", pulses);
      end
      drain(4);
   endtask

   task automatic test_reset_midflight();
      for (int k = 0; k < 3; k++) begin next_cycle(); i_if_vld = 1; end
      next_cycle(); i_reset = 0; i_if_vld = 1;
      #2;
      total++;
      if (obs !== 12'b0) begin
         bad++; $display("FAIL midreset_asserted: got %b want %b", obs, 12'b0);
      end
      for (int k = 0; k < 6; k++) begin
         next_cycle();
         i_reset = 1; i_if_vld = 0;
         #2;
         total++;
         if (obs !== 12'b0) begin
            bad++; $display("FAIL midreset_after[%0d]: got %b want %b", k, obs, 12'b0);
         end
      end
      drain(2);
   endtask

   initial begin
      idle();
      i_reset = 0;
      test_reset();
      test_load_use();
      test_fwd_priority();
      test_mispredict();
      test_freeze_mispred();
      test_back_to_back();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
